stream_vector_player: RTL and testbench

//  Synthesizable stimulus source; the transmit end of the per-file compare stream.

---
 rtl/stream_player_pkg.sv | 26 ++
 rtl/stream_player_ram.sv | 38 +++
 rtl/stream_vector_player.sv | 193 +++++++++++++++++++
 tb/tb_stream_vector_player.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_player_pkg.sv
// rtl/stream_player_pkg.sv - shared types and default widths for the vector player
package stream_player_pkg;

    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_DEPTH        = 1024;
    localparam int DEF_MAX_SEGMENTS = 8;
    localparam int DEF_AW           = $clog2(DEF_DEPTH);
    localparam int DEF_SW           = $clog2(DEF_MAX_SEGMENTS);

    // Segment descriptor at the default widths: first RAM word and word count
    typedef struct packed {
        logic [DEF_AW-1:0] base;
        logic [DEF_AW:0]   len;
    } seg_desc_s;

    typedef enum logic [2:0] {
        IDLE,
        SEG_INIT,
        FETCH,
        PLAY,
        GAP,
        SEG_END,
        DONE
    } player_state_e;

endpackage

// File: rtl/stream_player_ram.sv
// rtl/stream_player_ram.sv - simple dual-port vector RAM, sync write, 1-cycle sync read
module stream_player_ram #(
    parameter int  DATA_WIDTH = 32,
    parameter int  DEPTH      = 1024,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [AW-1:0]         wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [AW-1:0]         rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Storage array: contents survive reset
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read register holds its word until the next read is issued
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/stream_vector_player.sv
// rtl/stream_vector_player.sv - segment-list vector player, valid/ready output; STREAM_PLAYER_GAP_EN adds inter-word gaps
module stream_vector_player
    import stream_player_pkg::*;
#(
    parameter int  DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int  DEPTH        = DEF_DEPTH,
    parameter int  MAX_SEGMENTS = DEF_MAX_SEGMENTS,
    localparam int AW           = $clog2(DEPTH),
    localparam int SW           = $clog2(MAX_SEGMENTS)
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef STREAM_PLAYER_GAP_EN
    input  logic [7:0]            gap_cycles,
`endif
    input  logic                  load_we,
    input  logic [AW-1:0]         load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  seg_we,
    input  logic [SW-1:0]         seg_idx,
    input  logic [AW-1:0]         seg_base,
    input  logic [AW:0]           seg_len,
    input  logic [SW:0]           num_segments,
    input  logic                  start,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SW-1:0]         seg_index,
    output logic                  seg_done,
    output logic                  all_done,
    output logic                  busy
);

    typedef struct packed {
        logic [AW-1:0] base;
        logic [AW:0]   len;
    } desc_t;

    player_state_e         state_q, state_d;
    desc_t                 desc_q [MAX_SEGMENTS];
    desc_t                 cur_desc;
    logic [SW-1:0]         seg_q, seg_d;
    logic [SW:0]           num_q, num_d;
    logic [AW-1:0]         addr_q, addr_d, addr_next;
    logic [AW:0]           rem_q, rem_d;
    logic                  rd_en;
    logic [AW-1:0]         rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  busy_w;
    logic                  playing;
`ifdef STREAM_PLAYER_GAP_EN
    logic [7:0]            gap_q, gap_d;
`endif

    assign busy_w   = (state_q != IDLE) && (state_q != DONE);
    assign playing  = (state_q == PLAY);
    assign cur_desc = desc_q[seg_q];
    // Running address wraps at DEPTH-1 so non-power-of-two depths also wrap correctly
    assign addr_next = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);

    stream_player_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_ram (
        .clk_i    (clk),
        .rst_i    (reset),
        .wr_en_i  (load_we && !busy_w),
        .wr_addr_i(load_addr),
        .wr_data_i(load_data),
        .rd_en_i  (rd_en),
        .rd_addr_i(rd_addr),
        .rd_data_o(rd_data)
    );

    // Descriptor table: cleared on reset, frozen while playing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MAX_SEGMENTS; i++) begin
                desc_q[i] <= '0;
            end
        end else if (seg_we && !busy_w) begin
            desc_q[seg_idx].base <= seg_base;
            desc_q[seg_idx].len  <= seg_len;
        end
    end

    // FSM state and playback counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            seg_q   <= '0;
            num_q   <= '0;
            addr_q  <= '0;
            rem_q   <= '0;
`ifdef STREAM_PLAYER_GAP_EN
            gap_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            seg_q   <= seg_d;
            num_q   <= num_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
`ifdef STREAM_PLAYER_GAP_EN
            gap_q   <= gap_d;
`endif
        end
    end

    // Next state, RAM read issue and counter updates
    always_comb begin
        state_d = state_q;
        seg_d   = seg_q;
        num_d   = num_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        rd_en   = 1'b0;
        rd_addr = addr_q;
`ifdef STREAM_PLAYER_GAP_EN
        gap_d   = gap_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = SEG_INIT;
                    seg_d   = '0;
                    num_d   = num_segments;
                end
            end
            SEG_INIT: begin
                rem_d  = cur_desc.len;
                addr_d = cur_desc.base;
                if (num_q == '0) begin
                    state_d = DONE;
                end else if (cur_desc.len == '0) begin
                    state_d = SEG_END;
                end else begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                rd_en   = 1'b1;
                rd_addr = addr_q;
                state_d = PLAY;
            end
            PLAY: begin
                if (out_ready) begin
                    if (rem_q == (AW+1)'(1)) begin
                        state_d = SEG_END;
                    end else begin
                        // Prefetch the next word so the following cycle can transfer too
                        rem_d   = rem_q - (AW+1)'(1);
                        addr_d  = addr_next;
                        rd_en   = 1'b1;
                        rd_addr = addr_next;
`ifdef STREAM_PLAYER_GAP_EN
                        if (gap_cycles != 8'd0) begin
                            state_d = GAP;
                            gap_d   = gap_cycles;
                        end
`endif
                    end
                end
            end
`ifdef STREAM_PLAYER_GAP_EN
            GAP: begin
                if (gap_q <= 8'd1) begin
                    state_d = PLAY;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
`endif
            SEG_END: begin
                if (({1'b0, seg_q} + (SW+1)'(1)) < num_q) begin
                    seg_d   = seg_q + SW'(1);
                    state_d = SEG_INIT;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_valid = playing;
    assign out_data  = playing ? rd_data : '0;
    assign seg_index = seg_q;
    assign seg_done  = (state_q == SEG_END);
    assign all_done  = (state_q == DONE);
    assign busy      = busy_w;

endmodule

// File: tb/tb_stream_vector_player.sv
// tb/tb_stream_vector_player.sv - scoreboard bench for stream_vector_player
module tb_stream_vector_player;
    import stream_player_pkg::*;

    localparam int DW    = DEF_DATA_WIDTH;
    localparam int DEPTH = DEF_DEPTH;
    localparam int AW    = DEF_AW;
    localparam int SW    = DEF_SW;
    localparam int NSEG  = DEF_MAX_SEGMENTS;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_we = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [DW-1:0] load_data = '0;
    logic          seg_we = 1'b0;
    logic [SW-1:0] seg_idx = '0;
    logic [AW-1:0] seg_base = '0;
    logic [AW:0]   seg_len = '0;
    logic [SW:0]   num_segments = '0;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic [SW-1:0] seg_index;
    logic          seg_done;
    logic          all_done;
    logic          busy;
`ifdef STREAM_PLAYER_GAP_EN
    logic [7:0]    gap_cycles = 8'd0;
`endif

    stream_vector_player dut (
        .clk         (clk),
        .reset       (rst),
`ifdef STREAM_PLAYER_GAP_EN
        .gap_cycles  (gap_cycles),
`endif
        .load_we     (load_we),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .seg_we      (seg_we),
        .seg_idx     (seg_idx),
        .seg_base    (seg_base),
        .seg_len     (seg_len),
        .num_segments(num_segments),
        .start       (start),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .seg_index   (seg_index),
        .seg_done    (seg_done),
        .all_done    (all_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: RAM image, descriptor table, expected stream and seg_done order
    logic [DW-1:0] ram_m [DEPTH];
    seg_desc_s     seg_m [NSEG];
    logic [DW-1:0] exp_q [$];
    int            exp_seg_q [$];

    int          rmode = 0;
    logic        man_ready = 1'b0;
    int          fv, sd, ad;
    logic [31:0] vhist;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sink ready pattern: 0 always, 1 toggles 1,0,0, 2 random, 3 manual
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = (ph % 3 == 0);
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = man_ready;
            endcase
            ph++;
        end
    end

    // Monitor: pops the scoreboard on each accepted word and each seg_done pulse
    initial begin
        logic          pend;
        logic [DW-1:0] pend_data;
        pend = 1'b0;
        pend_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_data", out_data, pend_data);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_word: got %0h expected no word", out_data);
                    end else begin
                        chk("word", out_data, exp_q.pop_front());
                    end
                    pend = 1'b0;
                end else begin
                    pend = out_valid;
                    pend_data = out_data;
                end
                if (seg_done) begin
                    if (exp_seg_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_seg_done: got pulse at index %0d expected none", seg_index);
                    end else begin
                        chk("seg_done_index", seg_index, exp_seg_q.pop_front());
                    end
                end
            end
        end
    end

    // All driving tasks start and end at 1 time unit after a rising edge
    task automatic load_word(input int a, input logic [DW-1:0] d);
        load_we = 1'b1;
        load_addr = AW'(a);
        load_data = d;
        ram_m[a] = d;
        @(posedge clk);
        #1 load_we = 1'b0;
    endtask

    task automatic set_seg(input int idx, input int base, input int len);
        seg_we = 1'b1;
        seg_idx = SW'(idx);
        seg_base = AW'(base);
        seg_len = (AW+1)'(len);
        seg_m[idx].base = AW'(base);
        seg_m[idx].len = (AW+1)'(len);
        @(posedge clk);
        #1 seg_we = 1'b0;
    endtask

    task automatic run(input int num, input int mode, input bit stray, input bit same_load);
        int cyc;
        if (same_load) begin
            load_we = 1'b1;
            load_addr = '0;
            load_data = $urandom;
            ram_m[0] = load_data;
        end
        for (int s = 0; s < num; s++) begin
            for (int k = 0; k < int'(seg_m[s].len); k++) begin
                exp_q.push_back(ram_m[(int'(seg_m[s].base) + k) % DEPTH]);
            end
            exp_seg_q.push_back(s);
        end
        rmode = mode;
        num_segments = (SW+1)'(num);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        load_we = 1'b0;
        if (stray) begin
            load_we = 1'b1;
            load_addr = '0;
            load_data = ~ram_m[0];
            seg_we = 1'b1;
            seg_idx = '0;
            seg_base = AW'(5);
            seg_len = '0;
        end
        cyc = 1;
        fv = -1;
        sd = -1;
        ad = -1;
        vhist = '0;
        while (ad < 0 && cyc < 400) begin
            @(negedge clk);
            if (cyc < 32) vhist[cyc] = out_valid;
            if (fv < 0 && out_valid) fv = cyc;
            if (sd < 0 && seg_done) sd = cyc;
            if (all_done) ad = cyc;
            @(posedge clk);
            #1 load_we = 1'b0;
            seg_we = 1'b0;
            cyc++;
        end
        chk("all_done_reached", ad >= 0, 1);
        chk("busy_after_done", busy, 0);
        chk("words_outstanding", exp_q.size(), 0);
        chk("seg_done_outstanding", exp_seg_q.size(), 0);
        exp_q.delete();
        exp_seg_q.delete();
    endtask

    initial begin
        int n;
        for (int i = 0; i < NSEG; i++) seg_m[i] = '0;
        for (int i = 0; i < DEPTH; i++) ram_m[i] = '0;

        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_seg_index", seg_index, 0);
        chk("rst_seg_done", seg_done, 0);
        chk("rst_all_done", all_done, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Cleared table: one zero-length segment, no words
        run(1, 0, 0, 0);
        chk("cleared_table_seg_done_cycle", sd, 2);
        chk("cleared_table_all_done_cycle", ad, 3);

        // Back-to-back latency
        for (int i = 0; i < 4; i++) load_word(i, DW'(i + 1));
        set_seg(0, 0, 4);
        run(1, 0, 0, 0);
        chk("b2b_first_valid", fv, 3);
        chk("b2b_seg_done", sd, 7);
        chk("b2b_all_done", ad, 8);
        chk("b2b_valid_run", vhist[7:3], 5'b01111);

        // No segments
        run(0, 0, 0, 0);
        chk("empty_all_done", ad, 2);
        chk("empty_no_seg_done", sd, -1);
        chk("empty_no_valid", fv, -1);

        // Backpressure with writes attempted while busy
        run(1, 1, 1, 0);
        // Table must still hold {0,4}; same-cycle load+start must be playable
        run(1, 1, 0, 1);

        // Abort with word 2 pending
        rmode = 3;
        man_ready = 1'b0;
        exp_q.push_back(ram_m[0]);
        num_segments = 1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        chk("abort_first_valid", out_valid, 1);
        man_ready = 1'b1;
        @(posedge clk);
        #2 man_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_pending_valid", out_valid, 1);
        chk("abort_pending_data", out_data, ram_m[1]);
        #2 rst = 1'b1;
        #1;
        chk("abort_valid_low", out_valid, 0);
        chk("abort_busy_low", busy, 0);
        chk("abort_word1_consumed", exp_q.size(), 0);
        exp_q.delete();
        exp_seg_q.delete();
        for (int i = 0; i < NSEG; i++) seg_m[i] = '0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        rmode = 0;
        set_seg(0, 0, 4);
        run(1, 0, 0, 0);
        chk("replay_first_valid", fv, 3);

        // Multi-segment with an empty segment
        load_word(0, $urandom);
        load_word(1, $urandom);
        for (int i = 20; i < 23; i++) load_word(i, $urandom);
        set_seg(0, 0, 2);
        set_seg(1, 10, 0);
        set_seg(2, 20, 3);
        run(3, 2, 0, 0);

        // Wrap past the top of the RAM
        for (int i = 0; i < 4; i++) load_word((1022 + i) % DEPTH, $urandom);
        set_seg(0, 1022, 4);
        run(1, 1, 0, 0);

        // Randomised segment lists
        for (int r = 0; r < 6; r++) begin
            int nsg;
            nsg = $urandom_range(0, NSEG);
            for (int s = 0; s < nsg; s++) begin
                int b, l;
                b = $urandom_range(0, DEPTH - 1);
                l = $urandom_range(0, 5);
                set_seg(s, b, l);
                for (int k = 0; k < l; k++) load_word((b + k) % DEPTH, $urandom);
            end
            run(nsg, 2, 0, 0);
        end

`ifdef STREAM_PLAYER_GAP_EN
        gap_cycles = 8'd2;
        set_seg(0, 0, 3);
        run(1, 0, 0, 0);
        chk("gap_valid_pattern", vhist[9:3], 7'b1001001);
        gap_cycles = 8'd0;
        set_seg(0, 0, 4);
        run(1, 0, 0, 0);
        chk("gap0_first_valid", fv, 3);
        chk("gap0_seg_done", sd, 7);
        chk("gap0_all_done", ad, 8);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
